fifo_write_port: RTL and testbench
==================================

// Module: fifo_write_port
// PURPOSE
//  Write side of the 8-entry FIFO: owns the 8 data registers, the write pointer,
//  the occupancy count and the write handshake. Register outputs to_reg0..7 feed
//  the FIFO read multiplexer. The read controller reports each completed pop on
//  rd_pop so this block keeps count and full consistent with the read side.
// PARAMETERS
//  DATA_WIDTH  32  width of each entry, din and to_regN
//  (depth fixed at 8 entries; pointer 3 bits, count 4 bits)
// PORTS
//  clk      in   1           single clock; all state updates on rising edge
//  reset    in   1           synchronous, active-high reset
//  wr_en    in   1           write request, sampled each rising edge
//  din      in   DATA_WIDTH  write data, sampled with wr_en
//  rd_pop   in   1           read side removed one entry this cycle (pulse)
//  to_reg0..to_reg7 out DATA_WIDTH  storage register contents
//  wr_ptr   out  3           index of the next entry to write
//  count    out  4           entries held, 0..8
//  full     out  1           count==8 (combinational from count register)
//  empty    out  1           count==0 (combinational from count register)
//  wr_ack   out  1           registered: previous-edge write accepted
//  wr_err   out  1           registered: previous-edge write rejected (full)
// BEHAVIOUR
//  - Reset (reset=1 at edge): to_reg0..7=0, wr_ptr=0, count=0, state=INIT;
//    so wr_ack=0, wr_err=0, full=0, empty=1. Reset wins over every other input.
//  - State register {INIT, NO_OP, WRITE, WR_ERROR}, next state evaluated at each
//    non-reset edge from values sampled that edge (full = pre-edge count):
//    wr_en & ~full -> WRITE; wr_en & full -> WR_ERROR; ~wr_en -> NO_OP.
//    INIT is entered only by reset. wr_ack = (state==WRITE),
//    wr_err = (state==WR_ERROR); both single-cycle per request, one cycle late.
//  - Accepted write: to_reg[wr_ptr] <= din; wr_ptr <= wr_ptr+1 mod 8 (7->0 wrap).
//    New data is visible on to_regN the cycle after the edge. Other registers hold.
//  - Rejected write: no register, pointer or count change.
//  - Count update per edge: +1 on accepted write only; -1 on rd_pop only;
//    unchanged when both occur together, or neither.
//  - Write at full with simultaneous rd_pop is still rejected (full is pre-edge).
//  - rd_pop while count==0 is ignored (count stays 0; read side flags its error).
//  - Count arithmetic 4-bit unsigned; never exceeds 8, never below 0.
//  - din is don't-care when wr_en=0; no combinational path din->outputs.
// TESTING
//  1 Reset then idle 3 cycles -> to_reg0..7=0, wr_ptr=0, count=0, empty=1,
//    wr_ack=wr_err=0.
//  2 Write 0x11111111..0x88888888 on 8 consecutive cycles -> to_regN = data N+1,
//    wr_ptr wraps to 0, count=8, full=1, wr_ack high 8 cycles, each one late.
//  3 From full, wr_en with din=0xDEADBEEF -> wr_err=1 next cycle, wr_ack=0,
//    to_reg0 still 0x11111111, count=8.
//  4 From full, wr_en and rd_pop same edge -> write rejected, wr_err=1, count=7;
//    next edge wr_en din=0xCAFE0000 -> to_reg0=0xCAFE0000, count=8, wr_ptr=1.
//  5 count=3, wr_en and rd_pop same edge -> count stays 3, wr_ptr advances by 1;
//    rd_pop at count=0 -> count stays 0.
//  6 Assert reset mid-burst with wr_en held high -> next cycle all outputs at reset
//    values, wr_ack=0; writes resume at to_reg0 after reset deasserts.

Source files
------------

// File: rtl/fifo_write_port.sv
// Write side of the 8-entry FIFO: storage registers, write pointer, occupancy
// count and the registered write handshake (wr_ack / wr_err one cycle late).
module fifo_write_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_pop,
    output logic [DATA_WIDTH-1:0] to_reg0,
    output logic [DATA_WIDTH-1:0] to_reg1,
    output logic [DATA_WIDTH-1:0] to_reg2,
    output logic [DATA_WIDTH-1:0] to_reg3,
    output logic [DATA_WIDTH-1:0] to_reg4,
    output logic [DATA_WIDTH-1:0] to_reg5,
    output logic [DATA_WIDTH-1:0] to_reg6,
    output logic [DATA_WIDTH-1:0] to_reg7,
    output logic [2:0]            wr_ptr,
    output logic [3:0]            count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic [1:0]            o_dbg_state
);

    // Handshake: a write is offered whenever wr_en is high at a rising edge.
    // It is accepted iff the pre-edge count is below 8; the outcome appears on
    // wr_ack (accepted) or wr_err (rejected) for exactly one cycle afterwards.
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        NO_OP    = 2'd1,
        WRITE    = 2'd2,
        WR_ERROR = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_wr_ack;
    logic                  r_wr_err;
    logic [DATA_WIDTH-1:0] r_mem [8];
    logic [2:0]            r_wr_ptr;
    logic [3:0]            r_count;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_pop;

    assign w_full   = (r_count == 4'd8);
    assign w_empty  = (r_count == 4'd0);
    assign w_accept = wr_en & ~w_full;
    // A pop reported against an empty FIFO is the read side's error; ignore it.
    assign w_pop    = rd_pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= INIT;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_wr_ptr <= 3'd0;
            r_count  <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wr_en && !w_full) begin
                r_state  <= WRITE;
                r_wr_ack <= 1'b1;
                r_wr_err <= 1'b0;
            end else if (wr_en) begin
                r_state  <= WR_ERROR;
                r_wr_ack <= 1'b0;
                r_wr_err <= 1'b1;
            end else begin
                r_state  <= NO_OP;
                r_wr_ack <= 1'b0;
                r_wr_err <= 1'b0;
            end

            if (w_accept) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 3'd1;
            end

            if (w_accept && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    assign to_reg0     = r_mem[0];
    assign to_reg1     = r_mem[1];
    assign to_reg2     = r_mem[2];
    assign to_reg3     = r_mem[3];
    assign to_reg4     = r_mem[4];
    assign to_reg5     = r_mem[5];
    assign to_reg6     = r_mem[6];
    assign to_reg7     = r_mem[7];
    assign wr_ptr      = r_wr_ptr;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign wr_ack      = r_wr_ack;
    assign wr_err      = r_wr_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_write_port.sv
// Directed bench for fifo_write_port: hand-computed expectations for reset,
// fill, overflow, simultaneous write/pop and reset-mid-burst cases.
module tb_fifo_write_port;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] din;
    logic        rd_pop;
    logic [31:0] to_reg0, to_reg1, to_reg2, to_reg3;
    logic [31:0] to_reg4, to_reg5, to_reg6, to_reg7;
    logic [2:0]  wr_ptr;
    logic [3:0]  count;
    logic        full, empty, wr_ack, wr_err;
    logic [1:0]  o_dbg_state;
    logic [31:0] regs [8];

    int n_cmp = 0;
    int n_err = 0;

    fifo_write_port #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_pop(rd_pop),
        .to_reg0(to_reg0), .to_reg1(to_reg1), .to_reg2(to_reg2), .to_reg3(to_reg3),
        .to_reg4(to_reg4), .to_reg5(to_reg5), .to_reg6(to_reg6), .to_reg7(to_reg7),
        .wr_ptr(wr_ptr), .count(count), .full(full), .empty(empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .o_dbg_state(o_dbg_state)
    );

    assign regs[0] = to_reg0;
    assign regs[1] = to_reg1;
    assign regs[2] = to_reg2;
    assign regs[3] = to_reg3;
    assign regs[4] = to_reg4;
    assign regs[5] = to_reg5;
    assign regs[6] = to_reg6;
    assign regs[7] = to_reg7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; rd_pop = 1'b0; din = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write(input logic [31:0] d);
        wr_en = 1'b1; din = d; rd_pop = 1'b0;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_pop = 1'b0; din = '0;
        #1;
        do_reset();

        // 1: reset then idle
        check("rst_state", {30'd0, o_dbg_state}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 8; i++) check($sformatf("idle_reg%0d", i), regs[i], 32'h0);
        check("idle_ptr", {29'd0, wr_ptr}, 32'd0);
        check("idle_count", {28'd0, count}, 32'd0);
        check("idle_empty", {31'd0, empty}, 32'd1);
        check("idle_full", {31'd0, full}, 32'd0);
        check("idle_ack", {31'd0, wr_ack}, 32'd0);
        check("idle_err", {31'd0, wr_err}, 32'd0);
        check("idle_state", {30'd0, o_dbg_state}, 32'd1);

        // 2: fill with 0x11111111 .. 0x88888888
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = 32'h11111111 * (i + 1);
            step();
            check($sformatf("fill_ack%0d", i), {31'd0, wr_ack}, 32'd1);
            check($sformatf("fill_cnt%0d", i), {28'd0, count}, i + 1);
            check($sformatf("fill_reg%0d", i), regs[i], 32'h11111111 * (i + 1));
        end
        wr_en = 1'b0;
        check("fill_ptr", {29'd0, wr_ptr}, 32'd0);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_empty", {31'd0, empty}, 32'd0);
        step();
        check("fill_ack_drop", {31'd0, wr_ack}, 32'd0);

        // 3: overflow attempt
        write(32'hDEADBEEF);
        check("ovf_err", {31'd0, wr_err}, 32'd1);
        check("ovf_ack", {31'd0, wr_ack}, 32'd0);
        check("ovf_reg0", to_reg0, 32'h11111111);
        check("ovf_count", {28'd0, count}, 32'd8);
        check("ovf_ptr", {29'd0, wr_ptr}, 32'd0);
        check("ovf_state", {30'd0, o_dbg_state}, 32'd3);
        step();
        check("ovf_err_drop", {31'd0, wr_err}, 32'd0);

        // 4: write + pop at full -> rejected, then refill slot 0
        wr_en = 1'b1; rd_pop = 1'b1; din = 32'h12345678;
        step();
        check("fpop_err", {31'd0, wr_err}, 32'd1);
        check("fpop_count", {28'd0, count}, 32'd7);
        check("fpop_reg0", to_reg0, 32'h11111111);
        rd_pop = 1'b0; din = 32'hCAFE0000;
        step();
        wr_en = 1'b0;
        check("refill_reg0", to_reg0, 32'hCAFE0000);
        check("refill_count", {28'd0, count}, 32'd8);
        check("refill_ptr", {29'd0, wr_ptr}, 32'd1);
        check("refill_ack", {31'd0, wr_ack}, 32'd1);
        check("refill_reg1", to_reg1, 32'h22222222);

        // 5: write + pop at count 3, then drain and pop on empty
        do_reset();
        write(32'hA0A0A0A0);
        write(32'hB1B1B1B1);
        write(32'hC2C2C2C2);
        check("c3_count", {28'd0, count}, 32'd3);
        wr_en = 1'b1; rd_pop = 1'b1; din = 32'h44444444;
        step();
        wr_en = 1'b0;
        check("wp_count", {28'd0, count}, 32'd3);
        check("wp_ptr", {29'd0, wr_ptr}, 32'd4);
        check("wp_reg3", to_reg3, 32'h44444444);
        check("wp_ack", {31'd0, wr_ack}, 32'd1);
        for (int i = 0; i < 3; i++) step();
        rd_pop = 1'b0;
        check("drain_count", {28'd0, count}, 32'd0);
        check("drain_empty", {31'd0, empty}, 32'd1);
        rd_pop = 1'b1;
        step();
        rd_pop = 1'b0;
        check("upop_count", {28'd0, count}, 32'd0);
        check("upop_empty", {31'd0, empty}, 32'd1);
        check("upop_reg0", to_reg0, 32'hA0A0A0A0);

        // 6: reset mid-burst with wr_en held
        wr_en = 1'b1; din = 32'h55555555;
        step();
        din = 32'h66666666;
        step();
        check("burst_count", {28'd0, count}, 32'd2);
        reset = 1'b1; din = 32'h99999999;
        step();
        check("mrst_ack", {31'd0, wr_ack}, 32'd0);
        check("mrst_err", {31'd0, wr_err}, 32'd0);
        check("mrst_count", {28'd0, count}, 32'd0);
        check("mrst_ptr", {29'd0, wr_ptr}, 32'd0);
        check("mrst_empty", {31'd0, empty}, 32'd1);
        check("mrst_state", {30'd0, o_dbg_state}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("mrst_reg%0d", i), regs[i], 32'h0);
        reset = 1'b0; din = 32'h77777777;
        step();
        wr_en = 1'b0;
        check("resume_reg0", to_reg0, 32'h77777777);
        check("resume_reg1", to_reg1, 32'h0);
        check("resume_ptr", {29'd0, wr_ptr}, 32'd1);
        check("resume_ack", {31'd0, wr_ack}, 32'd1);
        check("resume_count", {28'd0, count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
